csel_subtractor_pipe: RTL and testbench
=======================================

Name: csel_subtractor_pipe

Overview:
Two-stage pipelined carry-select subtractor computing diff = a - b - bin with borrow out. It is the inverse-direction counterpart of the team's combinational carry-select adder. Internally it forms a + ~b + ~bin on carry-select blocks, and borrow out is the inverted carry. It sits on a valid/ready stream so it can be dropped into datapaths that stall.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of BLOCK.
BLOCK, 4, carry-select block width in bits; WIDTH/BLOCK >= 2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept an operand beat this cycle
a  in  WIDTH  minuend
b  in  WIDTH  subtrahend
bin  in  1  borrow in
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result this cycle
diff  out  WIDTH  (a - b - bin) mod 2^WIDTH
bout  out  1  borrow out; 1 iff unsigned a < b + bin
ovf  out  1  signed overflow of the subtraction
zero  out  1  diff == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: both stage valids = 0, out_valid = 0, diff = 0, bout = 0, ovf = 0, zero = 0.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Stage 1, on input transfer:
  - Block 0 computes its sum with carry-in = ~bin and registers it with its carry-out.
  - Every block k >= 1 computes and registers two candidate sums and carry-outs, one for carry-in 0 and one for carry-in 1, using a and ~b.
  - The sign bits of a and b are registered for ovf.
- Stage 2, on advance from stage 1:
  - Resolves the select chain block 0 -> N-1: each block's carry-in is the selected carry-out of the block below.
  - Registers diff, bout = ~final carry, zero, and ovf = (a_msb != b_msb) && (diff_msb != a_msb).
- Latency: 2 cycles from input transfer to out_valid with no stall.
- Throughput: 1 beat per cycle with out_ready held high.
- Pipeline stall rules:
  - Stage 2 may load when it is empty or transferring out this cycle.
  - Stage 1 may load when it is empty or advancing this cycle.
  - in_ready = ~s1_valid || s2_can_load. This is combinational from out_ready; there is no skid buffer.
  - Maximum 2 beats in flight.
- While out_valid = 1 and out_ready = 0, diff, bout, ovf and zero are held stable.
- Beats are never dropped, duplicated or reordered.
- in_valid held with in_ready = 0: no state change at stage 1.
- No deassertion requirement on the upstream. Operand values are only sampled on transfer.
- Simultaneous events: output transfer and new input in the same cycle with both stages full: all stages shift, occupancy stays 2, no bubble.
- Wrap-around: a = 0, b = 2^WIDTH-1, bin = 1 gives diff = 0, bout = 1, zero = 1.
- Reset mid-operation: in-flight beats are discarded, outputs return to reset values immediately, and in_ready = 1 on the first cycle after deassertion.
- Unknown or X values on a or b while in_valid = 0 must not propagate into valid flags.

Decomposition:
- Shared package csel_pkg: function for block count (WIDTH/BLOCK), a typedef for the per-block candidate record {sum0, c0, sum1, c1}, and an elaboration-time assertion helper for WIDTH % BLOCK == 0.
- One sub-module, csel_block: BLOCK-bit ripple adder pair producing both candidate sums and carries. It is instantiated WIDTH/BLOCK times in stage 1; block 0 uses only the path selected by ~bin.

Test Plan:
All values use WIDTH=16, BLOCK=4.
1. Basic: a=0x1234, b=0x0234, bin=0 with out_ready=1 -> 2 cycles later out_valid=1, diff=0x1000, bout=0, ovf=0, zero=0.
2. Borrow across all blocks: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x00FF, b=0x00FF, bin=1 -> diff=0xFFFF, bout=1, zero=0. Same operands with bin=0 -> diff=0x0000, bout=0, zero=1.
3. Signed overflow: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, ovf=1, bout=0. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1.
4. Backpressure: drive 4 back-to-back beats (a=10,20,30,40; b=1, bin=0) with out_ready=0 for 5 cycles -> in_ready=0 after 2 beats accepted, and out diff holds 9 stable. After out_ready rises, results 9, 19, 29, 39 arrive in order with no gaps or duplicates.
5. Full-throughput streaming: 100 random beats with in_valid=1 and out_ready=1 -> one result per cycle after a 2-cycle fill, each matching {bout, diff} == ({1'b0,a} - b - bin) masked to 17 bits.
6. Reset mid-flight: 2 beats in flight, assert rst asynchronously between clock edges -> out_valid=0 and diff=0 immediately. After release, no stale beat emerges, and a new beat (a=5, b=3) yields diff=2 two cycles after acceptance.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared helpers for the carry-select subtractor: block count, candidate record, geometry check.
package csel_pkg;

    localparam int BLOCK_MAX = 16;

    function automatic int block_count(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit geometry_ok(input int width, input int block);
        return (block > 0) && (block <= BLOCK_MAX) && ((width % block) == 0) && ((width / block) >= 2);
    endfunction

    // Only the low BLOCK bits of each sum field are meaningful.
    typedef struct packed {
        logic [BLOCK_MAX-1:0] sum0;
        logic                 c0;
        logic [BLOCK_MAX-1:0] sum1;
        logic                 c1;
    } cand_t;

endpackage

// File: rtl/csel_block.sv
// BLOCK-bit adder pair: both candidate sums and carry-outs, for carry-in 0 and carry-in 1.
module csel_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    output logic [BLOCK-1:0] sum0,
    output logic             c0,
    output logic [BLOCK-1:0] sum1,
    output logic             c1
);

    assign {c0, sum0} = {1'b0, x} + {1'b0, y};
    assign {c1, sum1} = {1'b0, x} + {1'b0, y} + (BLOCK+1)'(1);

endmodule

// File: rtl/csel_subtractor_pipe.sv
// Two-stage carry-select subtractor diff = a - b - bin on a valid/ready stream.
// Stage 1 builds per-block candidates of a + ~b, stage 2 resolves the select chain.
module csel_subtractor_pipe
    import csel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NB = block_count(WIDTH, BLOCK);

    if (!geometry_ok(WIDTH, BLOCK)) begin : g_bad_geometry
        $error("csel_subtractor_pipe: WIDTH must be a multiple of BLOCK with at least two blocks");
    end

    logic             s1_valid;
    cand_t            s1_cand [NB];
    logic             s1_a_msb;
    logic             s1_b_msb;
    logic             s2_can_load;
    logic             s1_adv;
    logic             in_fire;
    logic [WIDTH-1:0] nb;
    logic [BLOCK-1:0] blk_sum0 [NB];
    logic [BLOCK-1:0] blk_sum1 [NB];
    logic             blk_c0   [NB];
    logic             blk_c1   [NB];
    cand_t            cand_next [NB];
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             unused_cand;

    assign s2_can_load = ~out_valid | out_ready;
    assign s1_adv      = s1_valid & s2_can_load;
    assign in_ready    = ~s1_valid | s2_can_load;
    assign in_fire     = in_valid & in_ready;
    assign nb          = ~b;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        csel_block #(.BLOCK(BLOCK)) u_blk (
            .x    (a[k*BLOCK +: BLOCK]),
            .y    (nb[k*BLOCK +: BLOCK]),
            .sum0 (blk_sum0[k]),
            .c0   (blk_c0[k]),
            .sum1 (blk_sum1[k]),
            .c1   (blk_c1[k])
        );
    end

    // Block 0 is resolved immediately with carry-in = ~bin; its result lives in the sum0/c0 slot.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            cand_next[k] = '0;
            if (k == 0) begin
                cand_next[k].sum0[BLOCK-1:0] = bin ? blk_sum0[k] : blk_sum1[k];
                cand_next[k].c0              = bin ? blk_c0[k]   : blk_c1[k];
            end else begin
                cand_next[k].sum0[BLOCK-1:0] = blk_sum0[k];
                cand_next[k].c0              = blk_c0[k];
                cand_next[k].sum1[BLOCK-1:0] = blk_sum1[k];
                cand_next[k].c1              = blk_c1[k];
            end
        end
    end

    always_comb begin
        res       = '0;
        res_carry = s1_cand[0].c0;
        res[BLOCK-1:0] = s1_cand[0].sum0[BLOCK-1:0];
        for (int k = 1; k < NB; k++) begin
            res[k*BLOCK +: BLOCK] = res_carry ? s1_cand[k].sum1[BLOCK-1:0] : s1_cand[k].sum0[BLOCK-1:0];
            res_carry             = res_carry ? s1_cand[k].c1 : s1_cand[k].c0;
        end
    end

    always_comb begin
        unused_cand = 1'b0;
        for (int k = 0; k < NB; k++) begin
            unused_cand = unused_cand ^ (^s1_cand[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
            for (int k = 0; k < NB; k++) begin
                s1_cand[k] <= '0;
            end
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_a_msb <= a[WIDTH-1];
                s1_b_msb <= b[WIDTH-1];
                for (int k = 0; k < NB; k++) begin
                    s1_cand[k] <= cand_next[k];
                end
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (s1_adv) begin
                out_valid <= 1'b1;
                diff      <= res;
                bout      <= ~res_carry;
                zero      <= (res == '0);
                ovf       <= (s1_a_msb != s1_b_msb) && (res[WIDTH-1] != s1_a_msb);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csel_subtractor_pipe.sv
// Directed and random stream checks of csel_subtractor_pipe at WIDTH=16, BLOCK=4.
module tb_csel_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [18:0] exp;   // {ovf, zero, bout, diff}
    } beat_t;

    beat_t       tx_q [$];
    logic [18:0] exp_q [$];

    csel_subtractor_pipe #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        logic [16:0] r;
        int          s;
        logic        o;
        r = {1'b0, ma} - {1'b0, mb} - 17'(mbin);
        s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        o = (s > 32767) || (s < -32768);
        return {o, (r[15:0] == 16'h0), r[16], r[15:0]};
    endfunction

    task automatic push(input logic [15:0] pa, input logic [15:0] pb, input logic pbin, input logic [18:0] pexp);
        beat_t bt;
        bt.a = pa; bt.b = pb; bt.bin = pbin; bt.exp = pexp;
        tx_q.push_back(bt);
    endtask

    // Drives queued beats and checks every visible output against the scoreboard head.
    task automatic run(input logic ordy, input int max_it, output int it);
        logic do_in;
        logic do_out;
        it = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && it < max_it) begin
            @(negedge clk);
            out_ready = ordy;
            if (tx_q.size() > 0) begin
                in_valid = 1'b1;
                a = tx_q[0].a;
                b = tx_q[0].b;
                bin = tx_q[0].bin;
            end else begin
                in_valid = 1'b0;
                a = 'x;
                b = 'x;
                bin = 1'b0;
            end
            #1;
            do_in  = in_valid && in_ready;
            do_out = out_valid && out_ready;
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
                else chk(do_out ? "result" : "hold", 32'({ovf, zero, bout, diff}), 32'(exp_q[0]));
            end
            if (do_out && exp_q.size() > 0) void'(exp_q.pop_front());
            @(posedge clk);
            if (do_in) begin
                exp_q.push_back(tx_q[0].exp);
                void'(tx_q.pop_front());
            end
            it++;
        end
    endtask

    initial begin
        int it;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'({ovf, zero, bout, diff}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic, with exact fill latency
        push(16'h1234, 16'h0234, 1'b0, {1'b0, 1'b0, 1'b0, 16'h1000});
        run(1'b1, 20, it);
        chk("basic_latency", 32'(it), 32'd3);

        // Borrow chain, overflow and wrap-around vectors streamed back to back
        push(16'h0000, 16'h0001, 1'b0, {1'b0, 1'b0, 1'b1, 16'hFFFF});
        push(16'h00FF, 16'h00FF, 1'b1, {1'b0, 1'b0, 1'b1, 16'hFFFF});
        push(16'h00FF, 16'h00FF, 1'b0, {1'b0, 1'b1, 1'b0, 16'h0000});
        push(16'h8000, 16'h0001, 1'b0, {1'b1, 1'b0, 1'b0, 16'h7FFF});
        push(16'h7FFF, 16'hFFFF, 1'b0, {1'b1, 1'b0, 1'b1, 16'h8000});
        push(16'h0000, 16'hFFFF, 1'b1, {1'b0, 1'b1, 1'b1, 16'h0000});
        run(1'b1, 40, it);
        chk("directed_stream_cycles", 32'(it), 32'd8);

        // Backpressure: two beats accepted, then stall with first result held
        push(16'd10, 16'd1, 1'b0, {3'b000, 16'd9});
        push(16'd20, 16'd1, 1'b0, {3'b000, 16'd19});
        push(16'd30, 16'd1, 1'b0, {3'b000, 16'd29});
        push(16'd40, 16'd1, 1'b0, {3'b000, 16'd39});
        run(1'b0, 5, it);
        @(negedge clk);
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_accepted", 32'(4 - tx_q.size()), 32'd2);
        chk("stall_diff_held", 32'({out_valid, diff}), 32'({1'b1, 16'd9}));
        run(1'b1, 40, it);
        chk("stall_drained", 32'(tx_q.size() + exp_q.size()), 32'd0);

        // Full-throughput random stream
        for (int i = 0; i < 100; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            push(ra, rb, rbin, model(ra, rb, rbin));
        end
        run(1'b1, 400, it);
        chk("stream_cycles", 32'(it), 32'd102);

        // Reset with two beats in flight
        push(16'd100, 16'd1, 1'b0, {3'b000, 16'd99});
        push(16'd200, 16'd1, 1'b0, {3'b000, 16'd199});
        run(1'b1, 2, it);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_outputs", 32'({ovf, zero, bout, diff}), 32'd0);
        tx_q.delete();
        exp_q.delete();
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("postrst_no_stale", 32'(out_valid), 32'd0);
        end
        push(16'd5, 16'd3, 1'b0, {3'b000, 16'd2});
        run(1'b1, 20, it);
        chk("postrst_latency", 32'(it), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
